// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared types and constants for the run sequencer.
//   - state_t       : sequencer states (IDLE, LAUNCH, FILL, RUN, DONE)
//   - BR_OP_DEF     : default opcode of the branch instruction form
//   - HALT_INSTR_DEF: default full instruction word that ends a program
//   - field slices  : opcode Instr[8:6], branch offset Instr[5:0]
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        FILL   = 3'd2,
        RUN    = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [2:0] BR_OP_DEF      = 3'b111;
    localparam logic [8:0] HALT_INSTR_DEF = 9'h1FF;

    localparam int OPC_HI = 8;
    localparam int OPC_LO = 6;
    localparam int OFS_HI = 5;
    localparam int OFS_LO = 0;

    localparam int NUM_PROGS = 4;

    function automatic logic [2:0] opcode_of(input logic [8:0] instr);
        return instr[OPC_HI:OPC_LO];
    endfunction

    function automatic logic [5:0] offset_of(input logic [8:0] instr);
        return instr[OFS_HI:OFS_LO];
    endfunction

endpackage

// File: rtl/run_cycle_counter.sv
// run_cycle_counter: 16-bit RUN-cycle counter.
//   clk   in  : clock
//   rst   in  : asynchronous active-high reset (count -> 0)
//   clr   in  : synchronous clear (has priority over inc)
//   inc   in  : increment enable; the count saturates at 16'hFFFF
//   count out : current count
//   last  out : count equals MAX_CYCLES-1, i.e. the next counted cycle is the final one
module run_cycle_counter
    import run_ctrl_pkg::*;
#(
    parameter logic [15:0] MAX_CYCLES = 16'd4000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] count,
    output logic        last
);

    logic [15:0] count_reg;
    logic [15:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (inc && (count_reg != 16'hFFFF)) begin
            count_next = count_reg + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;
    assign last  = (count_reg == (MAX_CYCLES - 16'd1));

endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: program sequencer and branch decoder for the fetch unit.
//   CLK         in  : clock
//   Reset       in  : asynchronous active-high reset
//   Req         in  : harness run request (level)
//   Prog_Sel    in  : program select, sampled when a request is accepted
//   PC          in  : fetch PC, used only by the launch assertion
//   Instr       in  : registered-ROM word for the current PC
//   Start       out : one-cycle load strobe to fetch
//   Start_Addr  out : address fetch loads on Start
//   Branch      out : branch request (fetch applies its own Zero qualification)
//   Offset      out : branch offset Instr[5:0], 0 outside RUN
//   Run_En      out : datapath commit enable
//   Ack         out : program finished
//   Timeout     out : finish was forced by MAX_CYCLES
//   Cycle_Count out : RUN cycles of the last/current program
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter logic [7:0]  PROG0_ADDR = 8'd0,
    parameter logic [7:0]  PROG1_ADDR = 8'd64,
    parameter logic [7:0]  PROG2_ADDR = 8'd128,
    parameter logic [7:0]  PROG3_ADDR = 8'd192,
    parameter logic [2:0]  BR_OP      = BR_OP_DEF,
    parameter logic [8:0]  HALT_INSTR = HALT_INSTR_DEF,
    parameter logic [15:0] MAX_CYCLES = 16'd4000
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Req,
    input  logic [1:0]  Prog_Sel,
    input  logic [7:0]  PC,
    input  logic [8:0]  Instr,
    output logic        Start,
    output logic [7:0]  Start_Addr,
    output logic        Branch,
    output logic [5:0]  Offset,
    output logic        Run_En,
    output logic        Ack,
    output logic        Timeout,
    output logic [15:0] Cycle_Count
);

    localparam logic [NUM_PROGS*8-1:0] ADDR_TABLE =
        {PROG3_ADDR, PROG2_ADDR, PROG1_ADDR, PROG0_ADDR};

    logic [7:0] prog_addr [NUM_PROGS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PROGS; gi++) begin : g_prog_addr
            assign prog_addr[gi] = ADDR_TABLE[gi*8 +: 8];
        end
    endgenerate

    state_t     state_reg;
    state_t     state_next;
    logic [7:0] start_addr_reg;
    logic [7:0] start_addr_next;
    logic       timeout_reg;
    logic       timeout_next;

    logic       cnt_clr;
    logic       cnt_inc;
    logic       cnt_last;

    logic       is_halt;

    assign is_halt = (Instr == HALT_INSTR);

    run_cycle_counter #(
        .MAX_CYCLES (MAX_CYCLES)
    ) u_counter (
        .clk   (CLK),
        .rst   (Reset),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .count (Cycle_Count),
        .last  (cnt_last)
    );

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_reg      <= IDLE;
            start_addr_reg <= '0;
            timeout_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            start_addr_reg <= start_addr_next;
            timeout_reg    <= timeout_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        start_addr_next = start_addr_reg;
        timeout_next    = timeout_reg;
        cnt_clr         = 1'b0;
        cnt_inc         = 1'b0;
        Start           = 1'b0;
        Branch          = 1'b0;
        Offset          = '0;
        Run_En          = 1'b0;
        Ack             = 1'b0;

        case (state_reg)
            IDLE: begin
                if (Req) begin
                    start_addr_next = prog_addr[Prog_Sel];
                    timeout_next    = 1'b0;
                    cnt_clr         = 1'b1;
                    state_next      = LAUNCH;
                end
            end
            LAUNCH: begin
                Start      = 1'b1;
                state_next = FILL;
            end
            FILL: begin
                // ROM latency slot: Instr does not yet reflect the new PC.
                state_next = RUN;
            end
            RUN: begin
                Offset = offset_of(Instr);
                if (is_halt) begin
                    // HALT is checked first so it wins over a simultaneous timeout
                    // and its cycle is not counted.
                    state_next = DONE;
                end else begin
                    Run_En  = 1'b1;
                    Branch  = (opcode_of(Instr) == BR_OP);
                    cnt_inc = 1'b1;
                    if (cnt_last) begin
                        timeout_next = 1'b1;
                        state_next   = DONE;
                    end
                end
            end
            DONE: begin
                Ack = 1'b1;
                if (!Req) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign Start_Addr = start_addr_reg;
    assign Timeout    = timeout_reg;

    // Fetch must have loaded Start_Addr on the launch edge.
    a_launch_pc: assert property (@(posedge CLK) disable iff (Reset)
        Start |=> (PC == Start_Addr))
        else $error("launch PC differs from Start_Addr");

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: self-checking bench for run_ctrl (MAX_CYCLES overridden to 16).
// A small fetch model drives PC; the bench acts as the ROM by driving Instr directly.
module tb_run_ctrl;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        Req;
    logic [1:0]  Prog_Sel;
    logic [7:0]  PC;
    logic [8:0]  Instr;
    logic        Start;
    logic [7:0]  Start_Addr;
    logic        Branch;
    logic [5:0]  Offset;
    logic        Run_En;
    logic        Ack;
    logic        Timeout;
    logic [15:0] Cycle_Count;

    run_ctrl #(
        .MAX_CYCLES (16'd16)
    ) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .Req         (Req),
        .Prog_Sel    (Prog_Sel),
        .PC          (PC),
        .Instr       (Instr),
        .Start       (Start),
        .Start_Addr  (Start_Addr),
        .Branch      (Branch),
        .Offset      (Offset),
        .Run_En      (Run_En),
        .Ack         (Ack),
        .Timeout     (Timeout),
        .Cycle_Count (Cycle_Count)
    );

    always #5 CLK = ~CLK;

    // Fetch unit model: load on Start, advance or branch on Run_En.
    always @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            PC <= 8'd0;
        end else if (Start) begin
            PC <= Start_Addr;
        end else if (Run_En) begin
            PC <= Branch ? (PC + {2'b00, Offset}) : (PC + 8'd1);
        end
    end

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] count;
        logic        timeout;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic [1:0]  sel;
        int          nwords;
        logic        halts;
        logic [7:0]  exp_addr;
        logic [15:0] exp_count;
        logic        exp_to;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [34:0] all_outs();
        return {Start, Start_Addr, Branch, Offset, Run_En, Ack, Timeout, Cycle_Count};
    endfunction

    // Run one program from IDLE; Req is dropped in LAUNCH and Prog_Sel is
    // scrambled during RUN, both of which must be ignored.
    task automatic run_prog(input vec_t v, input int idx);
        exp_t e;
        exp_t got_e;
        int   runs;
        bit   got;
        Req      = 1'b1;
        Prog_Sel = v.sel;
        Instr    = 9'h000;
        e.addr    = v.exp_addr;
        e.count   = v.exp_count;
        e.timeout = v.exp_to;
        sb.push_back(e);
        @(negedge CLK);
        chk("launch_start", Start, 1);
        chk("launch_addr", Start_Addr, v.exp_addr);
        Req = 1'b0;
        @(negedge CLK);
        Instr = {3'b111, 6'd5};
        #1;
        chk("fill_start", Start, 0);
        chk("fill_branch", {Branch, Offset}, 0);
        chk("fill_run_en", Run_En, 0);
        @(negedge CLK);
        Prog_Sel = ~v.sel;
        runs = 0;
        got  = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (!v.halts || i < v.nwords) begin
                Instr = {3'($urandom_range(0, 6)), 6'($urandom)};
            end else begin
                Instr = 9'h1FF;
            end
            #1;
            if (Run_En) runs++;
            @(negedge CLK);
            if (Ack) got = 1'b1;
        end
        if (!got) begin
            errors++;
            checks++;
            $display("FAIL prog%0d_ack: no Ack within 40 cycles, required Ack=1", idx);
        end else begin
            got_e = sb.pop_front();
            chk("done_addr", Start_Addr, got_e.addr);
            chk("done_count", Cycle_Count, got_e.count);
            chk("done_timeout", Timeout, got_e.timeout);
            chk("run_en_cycles", runs, got_e.count);
        end
        $display("prog %0d sel=%0d addr=%0d count=%0d timeout=%0d run_en_cycles=%0d",
                 idx, v.sel, Start_Addr, Cycle_Count, Timeout, runs);
        @(negedge CLK);
        chk("idle_ack", Ack, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rv;

        vecs[0] = '{2'd2, 5,  1'b1, 8'd128, 16'd5,  1'b0};
        vecs[1] = '{2'd0, 0,  1'b1, 8'd0,   16'd0,  1'b0};
        vecs[2] = '{2'd1, 3,  1'b1, 8'd64,  16'd3,  1'b0};
        vecs[3] = '{2'd3, 0,  1'b0, 8'd192, 16'd16, 1'b1};
        vecs[4] = '{2'd2, 15, 1'b1, 8'd128, 16'd15, 1'b0};
        vecs[5] = '{2'd1, 16, 1'b1, 8'd64,  16'd16, 1'b1};

        Reset    = 1'b1;
        Req      = 1'b0;
        Prog_Sel = 2'd0;
        Instr    = 9'h000;
        repeat (2) @(negedge CLK);
        chk("reset_outputs", all_outs(), 0);
        Reset = 1'b0;
        @(negedge CLK);

        for (int k = 0; k < 6; k++) begin
            run_prog(vecs[k], k);
        end

        // Branch decode, Req held through DONE, and relaunch.
        Req      = 1'b1;
        Prog_Sel = 2'd1;
        @(negedge CLK);
        @(negedge CLK);
        @(negedge CLK);
        Instr = 9'b111_000011;
        #1;
        chk("br_branch", Branch, 1);
        chk("br_offset", Offset, 6'd3);
        chk("br_run_en", Run_En, 1);
        @(negedge CLK);
        Instr = 9'h0C5;
        #1;
        chk("nonbr_branch", Branch, 0);
        @(negedge CLK);
        Instr = 9'h1FF;
        #1;
        chk("halt_branch", Branch, 0);
        chk("halt_run_en", Run_En, 0);
        @(negedge CLK);
        chk("hold_count", Cycle_Count, 16'd2);
        for (int i = 0; i < 10; i++) begin
            chk("hold_ack", {Ack, Start}, 2'b10);
            @(negedge CLK);
        end
        $display("req held in DONE 10 cycles: Ack=%0d Start=%0d", Ack, Start);
        Req = 1'b0;
        @(negedge CLK);
        chk("release_ack", Ack, 0);
        Req      = 1'b1;
        Prog_Sel = 2'd2;
        @(negedge CLK);
        chk("relaunch_start", Start, 1);
        chk("relaunch_count", Cycle_Count, 0);
        chk("relaunch_addr", Start_Addr, 8'd128);
        Req = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        Instr = 9'h1FF;
        @(negedge CLK);
        chk("relaunch_done", {Ack, Timeout, Cycle_Count}, {1'b1, 1'b0, 16'd0});
        $display("relaunch sel=2 addr=%0d count=%0d", Start_Addr, Cycle_Count);
        @(negedge CLK);

        // Asynchronous reset mid-RUN, then a fresh launch of program 0.
        Req      = 1'b1;
        Prog_Sel = 2'd3;
        Instr    = 9'h000;
        @(negedge CLK);
        Req = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        repeat (10) @(negedge CLK);
        Instr = 9'b111_000011;
        #1;
        chk("pre_reset_count", Cycle_Count, 16'd10);
        chk("pre_reset_branch", Branch, 1);
        #1;
        Reset = 1'b1;
        #1;
        chk("async_reset_outputs", all_outs(), 0);
        $display("async reset mid-run: outputs=0x%0h", all_outs());
        @(negedge CLK);
        Reset = 1'b0;
        Instr = 9'h000;
        rv = '{2'd0, 2, 1'b1, 8'd0, 16'd2, 1'b0};
        run_prog(rv, 6);

        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
